// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access stage.
package mem_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Load encodings of funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store encodings of funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Byte mask for the access size; the low two bits carry the size
    // for both loads and stores (111 falls into the doubleword case).
    function automatic logic [7:0] size_mask(input logic [2:0] funct3);
        logic [7:0] m;
        case (funct3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural alignment: the offset must be a multiple of the access size.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] addr);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~addr[0];
            2'b10:   ok = (addr[1:0] == 2'b00);
            default: ok = (addr == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: shift the doubleword down to the accessed byte,
// then sign- or zero-extend according to funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    // Align and extend in one combinational step
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  data = {56'd0, shifted[7:0]};
            F3_LHU:  data = {48'd0, shifted[15:0]};
            F3_LWU:  data = {32'd0, shifted[31:0]};
            default: data = shifted;  // LD, and 111 treated as LD
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/ack bus, stalls the
// upstream pipe while a transaction is outstanding and drives the MEM/WB
// register plus the forwarding value back to the ALU.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inValid,
    input  logic [BUS_DATA_WIDTH-1:0] inResult,
    input  logic [BUS_DATA_WIDTH-1:0] inStoreData,
    input  logic [2:0]                inFunct3,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic                      inRegWrite,
    input  logic [4:0]                inDestReg,
    output logic                      memReq,
    output logic                      memWe,
    output logic [BUS_DATA_WIDTH-1:0] memAddr,
    output logic [BUS_DATA_WIDTH-1:0] memWdata,
    output logic [7:0]                memStrb,
    input  logic                      memAck,
    input  logic [BUS_DATA_WIDTH-1:0] memRdata,
    output logic                      outStall,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [BUS_DATA_WIDTH-1:0] outLoadData,
    output logic                      outMemOrReg,
    output logic                      outRegWrite,
    output logic [4:0]                outDestReg,
    output logic [BUS_DATA_WIDTH-1:0] outMemResult,
    output logic                      outMisaligned,
    output logic                      outBusError
);

    // Counter only needs to reach MEM_TIMEOUT-1; the timeout fires on that value.
    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [63:0]        addr_q, addr_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [7:0]         strb_q, strb_d;
    logic [2:0]         f3_q, f3_d;
    logic               lmor_q, lmor_d;
    logic               lrw_q, lrw_d;
    logic [4:0]         ldst_q, ldst_d;

    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_result_q, out_result_d;
    logic [63:0]        out_load_q, out_load_d;
    logic               out_mor_q, out_mor_d;
    logic               out_rw_q, out_rw_d;
    logic [4:0]         out_dst_q, out_dst_d;
    logic               out_mis_q, out_mis_d;
    logic               out_berr_q, out_berr_d;

    logic [63:0]        ld_data;
    logic [63:0]        st_rep;

    load_align u_load_align (
        .rdata  (memRdata),
        .offset (addr_q[2:0]),
        .funct3 (f3_q),
        .data   (ld_data)
    );

    // Replicate the low store bytes across every byte lane
    always_comb begin
        case (inFunct3[1:0])
            2'b00:   st_rep = {8{inStoreData[7:0]}};
            2'b01:   st_rep = {4{inStoreData[15:0]}};
            2'b10:   st_rep = {2{inStoreData[31:0]}};
            default: st_rep = inStoreData;
        endcase
    end

    // Next-state, bus and MEM/WB register computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        f3_d         = f3_q;
        lmor_d       = lmor_q;
        lrw_d        = lrw_q;
        ldst_d       = ldst_q;
        out_valid_d  = 1'b0;
        out_result_d = out_result_q;
        out_load_d   = out_load_q;
        out_mor_d    = out_mor_q;
        out_rw_d     = out_rw_q;
        out_dst_d    = out_dst_q;
        out_mis_d    = 1'b0;
        out_berr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (inValid) begin
                    if (!(inMemRead || inMemWrite)) begin
                        out_valid_d  = 1'b1;
                        out_result_d = inResult;
                        out_load_d   = '0;
                        out_mor_d    = inMemOrReg;
                        out_rw_d     = inRegWrite;
                        out_dst_d    = inDestReg;
                    end else if (!is_aligned(inFunct3, inResult[2:0])) begin
                        // Trap without touching the bus; suppress the write-back
                        out_valid_d  = 1'b1;
                        out_mis_d    = 1'b1;
                        out_result_d = inResult;
                        out_load_d   = '0;
                        out_mor_d    = inMemOrReg;
                        out_rw_d     = 1'b0;
                        out_dst_d    = inDestReg;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = inMemWrite;
                        addr_d  = inResult;
                        wdata_d = st_rep;
                        strb_d  = size_mask(inFunct3) << inResult[2:0];
                        f3_d    = inFunct3;
                        lmor_d  = inMemOrReg;
                        lrw_d   = inRegWrite;
                        ldst_d  = inDestReg;
                    end
                end
            end
            WAIT: begin
                if (memAck) begin
                    // Ack beats a simultaneous timeout
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    out_valid_d  = 1'b1;
                    out_result_d = addr_q;
                    out_load_d   = we_q ? 64'd0 : ld_data;
                    out_mor_d    = lmor_q;
                    out_rw_d     = lrw_q;
                    out_dst_d    = ldst_q;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d      = IDLE;
                    req_d        = 1'b0;
                    out_valid_d  = 1'b1;
                    out_berr_d   = 1'b1;
                    out_result_d = addr_q;
                    out_load_d   = '0;
                    out_mor_d    = lmor_q;
                    out_rw_d     = 1'b0;
                    out_dst_d    = ldst_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strb_q       <= '0;
            f3_q         <= '0;
            lmor_q       <= 1'b0;
            lrw_q        <= 1'b0;
            ldst_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_load_q   <= '0;
            out_mor_q    <= 1'b0;
            out_rw_q     <= 1'b0;
            out_dst_q    <= '0;
            out_mis_q    <= 1'b0;
            out_berr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            f3_q         <= f3_d;
            lmor_q       <= lmor_d;
            lrw_q        <= lrw_d;
            ldst_q       <= ldst_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_load_q   <= out_load_d;
            out_mor_q    <= out_mor_d;
            out_rw_q     <= out_rw_d;
            out_dst_q    <= out_dst_d;
            out_mis_q    <= out_mis_d;
            out_berr_q   <= out_berr_d;
        end
    end

    assign memReq        = req_q;
    assign memWe         = we_q;
    assign memAddr       = {addr_q[63:3], 3'b000};
    assign memWdata      = wdata_q;
    assign memStrb       = strb_q;
    assign outStall      = (state_q == WAIT);
    assign outValid      = out_valid_q;
    assign outResult     = out_result_q;
    assign outLoadData   = out_load_q;
    assign outMemOrReg   = out_mor_q;
    assign outRegWrite   = out_rw_q;
    assign outDestReg    = out_dst_q;
    assign outMemResult  = out_mor_q ? out_load_q : out_result_q;
    assign outMisaligned = out_mis_q;
    assign outBusError   = out_berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver pushes expected MEM/WB contents,
// a bus responder answers requests, a monitor pops and compares.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic [63:0] inResult = '0, inStoreData = '0;
    logic [2:0]  inFunct3 = '0;
    logic        inMemRead = 1'b0, inMemWrite = 1'b0, inMemOrReg = 1'b0, inRegWrite = 1'b0;
    logic [4:0]  inDestReg = '0;
    logic        memReq, memWe, memAck;
    logic [63:0] memAddr, memWdata, memRdata;
    logic [7:0]  memStrb;
    logic        outStall, outValid, outMemOrReg, outRegWrite, outMisaligned, outBusError;
    logic [63:0] outResult, outLoadData, outMemResult;
    logic [4:0]  outDestReg;

    mem_stage dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inResult(inResult),
        .inStoreData(inStoreData), .inFunct3(inFunct3), .inMemRead(inMemRead),
        .inMemWrite(inMemWrite), .inMemOrReg(inMemOrReg), .inRegWrite(inRegWrite),
        .inDestReg(inDestReg), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memStrb(memStrb), .memAck(memAck), .memRdata(memRdata),
        .outStall(outStall), .outValid(outValid), .outResult(outResult),
        .outLoadData(outLoadData), .outMemOrReg(outMemOrReg), .outRegWrite(outRegWrite),
        .outDestReg(outDestReg), .outMemResult(outMemResult),
        .outMisaligned(outMisaligned), .outBusError(outBusError)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int err = 0;

    typedef struct {
        logic [63:0] result;
        logic [63:0] load;
        logic [63:0] memres;
        logic        mor;
        logic        rw;
        logic        mis;
        logic        berr;
        logic [4:0]  dst;
    } exp_t;

    exp_t sb[$];

    // Bus plan for the transaction currently issued
    logic        bus_exp = 1'b0;
    logic        exp_we = 1'b0;
    logic [63:0] exp_addr = '0, exp_wdata = '0, plan_rdata = '0;
    logic [7:0]  exp_strb = '0;
    int          plan_delay = 0;   // 0: never acknowledge
    bit          skip_len = 1'b0;
    int          wcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load: pick nb bytes at the offset, extend by signedness
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] rd, input int off);
        int nb;
        logic [63:0] v, m;
        nb = (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
        v = rd >> (8 * off);
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (!f3[2] && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    task automatic launch(input logic [2:0] f3, input bit rd, input bit wr, input bit mor,
                          input bit rw, input logic [4:0] dst, input logic [63:0] res,
                          input logic [63:0] sd, input logic [63:0] rdata, input int delay);
        exp_t e;
        int nb, off;
        bit mem, al;
        logic [63:0] wd;
        nb  = (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
        off = int'(res[2:0]);
        mem = rd | wr;
        al  = (off % nb) == 0;
        e.result = res; e.mor = mor; e.dst = dst; e.rw = rw;
        e.mis = 1'b0; e.berr = 1'b0; e.load = '0;
        if (mem && !al) begin
            e.mis = 1'b1; e.rw = 1'b0;
        end else if (mem && delay == 0) begin
            e.berr = 1'b1; e.rw = 1'b0;
        end else if (rd && !wr) begin
            e.load = model_load(f3, rdata, off);
        end
        e.memres = e.mor ? e.load : e.result;
        for (int i = 0; i < 8; i++) wd[8*i +: 8] = sd[8*(i % nb) +: 8];
        @(negedge clk);
        bus_exp    = mem && al;
        exp_we     = wr;
        exp_addr   = {res[63:3], 3'b000};
        exp_wdata  = wd;
        exp_strb   = 8'(((1 << nb) - 1) << off);
        plan_rdata = rdata;
        plan_delay = delay;
        inValid = 1'b1; inFunct3 = f3; inMemRead = rd; inMemWrite = wr;
        inMemOrReg = mor; inRegWrite = rw; inDestReg = dst; inResult = res; inStoreData = sd;
        sb.push_back(e);
        @(negedge clk);
        // Garbage on the inputs while stalled must not be sampled
        inValid = 1'b0;
        inResult = {$urandom, $urandom}; inStoreData = {$urandom, $urandom};
        inFunct3 = 3'($urandom); inMemRead = 1'($urandom); inMemWrite = 1'($urandom);
    endtask

    task automatic issue(input logic [2:0] f3, input bit rd, input bit wr, input bit mor,
                         input bit rw, input logic [4:0] dst, input logic [63:0] res,
                         input logic [63:0] sd, input logic [63:0] rdata, input int delay);
        int n;
        launch(f3, rd, wr, mor, rw, dst, res, sd, rdata, delay);
        n = 0;
        while (outStall === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            vec++; err++;
            $display("FAIL stall_bound: outStall still %b after %0d cycles, required 0", outStall, n);
        end
        bus_exp = 1'b0;
    endtask

    // Monitor: every presented MEM/WB entry is popped and compared
    always @(negedge clk) begin
        exp_t e;
        if (outValid === 1'b1) begin
            if (sb.size() == 0) begin
                vec++; err++;
                $display("FAIL spurious_valid: outValid=1 with result %h, required no entry", outResult);
            end else begin
                e = sb.pop_front();
                chk("out_result", outResult, e.result);
                chk("out_load", outLoadData, e.load);
                chk("out_memres", outMemResult, e.memres);
                chk("out_mor", 64'(outMemOrReg), 64'(e.mor));
                chk("out_rw", 64'(outRegWrite), 64'(e.rw));
                chk("out_dst", 64'(outDestReg), 64'(e.dst));
                chk("out_mis", 64'(outMisaligned), 64'(e.mis));
                chk("out_berr", 64'(outBusError), 64'(e.berr));
            end
        end else begin
            chk("flags_idle", {62'd0, outMisaligned, outBusError}, 64'd0);
        end
    end

    // Bus responder: acks after plan_delay request cycles, checks held bus fields
    always @(negedge clk) begin
        if (memReq === 1'b1) begin
            wcnt++;
            if (!bus_exp) begin
                vec++; err++;
                $display("FAIL unexpected_req: memReq=1 addr %h, required no request", memAddr);
            end else begin
                chk("bus_addr", memAddr, exp_addr);
                chk("bus_we", 64'(memWe), 64'(exp_we));
                chk("bus_stall", 64'(outStall), 64'd1);
                if (exp_we) begin
                    chk("bus_wdata", memWdata, exp_wdata);
                    chk("bus_strb", 64'(memStrb), 64'(exp_strb));
                end
            end
            memAck   = (plan_delay != 0) && (wcnt == plan_delay);
            memRdata = memAck ? plan_rdata : {$urandom, $urandom};
        end else begin
            if (wcnt != 0) begin
                if (!skip_len) chk("req_len", 64'(wcnt), 64'((plan_delay == 0) ? 255 : plan_delay));
                skip_len = 1'b0;
                wcnt = 0;
            end
            // Stray acks outside a transaction must be ignored
            memAck   = ($urandom % 4) == 0;
            memRdata = {$urandom, $urandom};
        end
    end

    initial begin
        logic [2:0]  f3;
        logic [63:0] res;
        logic [2:0]  lo;
        int kind, nb, dly;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(outValid), 64'd0);
        chk("rst_req", 64'(memReq), 64'd0);
        chk("rst_stall", 64'(outStall), 64'd0);
        chk("rst_result", outResult, 64'd0);
        chk("rst_load", outLoadData, 64'd0);
        chk("rst_flags", {62'd0, outMisaligned, outBusError}, 64'd0);
        reset = 1'b0;

        // Non-memory pass-through
        issue(3'b000, 0, 0, 0, 1, 5'd5, 64'h1234, 64'h0, 64'h0, 1);
        // LB sign-extension, ack on 3rd WAIT cycle
        issue(3'b000, 1, 0, 1, 1, 5'd7, 64'h1003, 64'h0, 64'h00000000_80000000, 3);
        // SH upper half of the doubleword
        issue(3'b001, 0, 1, 0, 0, 5'd0, 64'h2006, 64'hABCD, 64'h0, 2);
        // Misaligned LW
        issue(3'b010, 1, 0, 1, 1, 5'd9, 64'h3002, 64'h0, 64'h0, 1);
        // LD timeout, then ack exactly on the timeout cycle
        issue(3'b011, 1, 0, 1, 1, 5'd3, 64'h4000, 64'h0, 64'h1122334455667788, 0);
        issue(3'b011, 1, 0, 1, 1, 5'd4, 64'h4008, 64'h0, 64'h8877665544332211, 255);
        // Ack in first WAIT cycle
        issue(3'b110, 1, 0, 1, 1, 5'd6, 64'h5004, 64'h0, 64'hF000000F_00000000, 1);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom % 4;
            f3   = (kind == 1 || kind == 2) ? 3'($urandom % 8) : 3'($urandom % 4);
            nb   = (f3[1:0] == 2'b11) ? 8 : (1 << f3[1:0]);
            res  = {$urandom, $urandom};
            if ($urandom % 3 != 0) begin
                lo = res[2:0] & 3'(~(nb - 1));
                res[2:0] = lo;
            end
            dly = ($urandom % 40 == 0) ? 0 : 1 + ($urandom % 5);
            issue(f3, (kind == 1 || kind == 2), (kind == 3), 1'($urandom), 1'($urandom),
                  5'($urandom), res, {$urandom, $urandom}, {$urandom, $urandom}, dly);
            repeat ($urandom % 3) @(negedge clk);
        end

        // Reset in the 2nd WAIT cycle abandons the load
        launch(3'b011, 1, 0, 1, 1, 5'd8, 64'h6000, 64'h0, 64'h0, 0);
        @(negedge clk);
        skip_len = 1'b1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("rstw_req", 64'(memReq), 64'd0);
        chk("rstw_valid", 64'(outValid), 64'd0);
        chk("rstw_stall", 64'(outStall), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_exp = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_valid", 64'(outValid), 64'd0);
            chk("post_rst_req", 64'(memReq), 64'd0);
        end

        // Pipe still works after the abandoned transaction
        issue(3'b100, 1, 0, 1, 1, 5'd2, 64'h7005, 64'h0, 64'h0000_F300_0000_0000, 2);
        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the registered ALU result and control bits; performs loads and stores over a req/ack data bus.
- Drives the MEM/WB pipeline register and the forwarding value fed back to the ALU's inMemResult.
- Stalls the upstream pipe while a bus transaction is outstanding.

Parameters:
- BUS_DATA_WIDTH, 64, datapath and bus data width; only 64 is supported.
- MEM_TIMEOUT, 255, maximum cycles spent in WAIT before a bus error is flagged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inValid  in  1  EX result valid this cycle
- inResult  in  64  ALU result: memory address for loads/stores, otherwise the write-back value
- inStoreData  in  64  forwarded rs2 value for stores
- inFunct3  in  3  access size and sign selector
- inMemRead  in  1  load
- inMemWrite  in  1  store
- inMemOrReg  in  1  write-back source select; 1 selects load data
- inRegWrite  in  1  register write enable
- inDestReg  in  5  destination register
- memReq  out  1  bus request
- memWe  out  1  1 means write
- memAddr  out  64  doubleword-aligned address ({addr[63:3],3'b0})
- memWdata  out  64  lane-replicated store data
- memStrb  out  8  byte strobes
- memAck  in  1  bus completion
- memRdata  in  64  read data, valid when memAck is high
- outStall  out  1  upstream must hold its inputs
- outValid  out  1  MEM/WB register valid
- outResult  out  64  pass-through ALU result
- outLoadData  out  64  aligned and extended load data
- outMemOrReg  out  1  registered copy of inMemOrReg
- outRegWrite  out  1  registered copy of inRegWrite
- outDestReg  out  5  registered copy of inDestReg
- outMemResult  out  64  forwarding value: outLoadData if outMemOrReg, else outResult
- outMisaligned  out  1  exception flag for a misaligned access
- outBusError  out  1  exception flag for a bus timeout

Behaviour:
- Reset: every registered output, memReq and the timeout counter go to 0; state goes to IDLE.
- Reset takes priority over every other event. Reset during WAIT abandons the transaction; memReq is 0 the following cycle.
- States are IDLE and WAIT. outStall = (state==WAIT), decoded from state only.
- IDLE, inValid=0: outValid <= 0 next edge.
- IDLE, inValid with neither inMemRead nor inMemWrite: MEM/WB register loads next edge (1-cycle latency); outLoadData <= 0.
- IDLE, inValid with a memory op: check alignment.
  - Natural alignment is required: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - Misaligned: no request; next edge outValid=1, outMisaligned=1, outRegWrite=0.
  - Aligned: latch address, data, funct3 and control; go to WAIT. memReq=1 from the next cycle.
- WAIT:
  - memReq, memWe, memAddr, memWdata and memStrb are held stable.
  - memAck may arrive in the first WAIT cycle.
  - On memAck: next edge state=IDLE, memReq=0, outValid=1, outLoadData = extracted memRdata (0 for stores).
  - Minimum memory-op latency is 2 cycles from accept to outValid.
- Timeout: the counter increments each WAIT cycle without memAck. When it reaches MEM_TIMEOUT:
  - drop the request and return to IDLE;
  - outValid=1, outBusError=1, outRegWrite=0.
  - memAck in the same cycle as the timeout wins: normal completion.
- memAck outside WAIT is ignored.
- Inputs are not sampled in WAIT. outValid=0 during WAIT cycles, except the completion cycle.
- Load extraction: shift memRdata right by addr[2:0]*8, then select by funct3:
  - 000 LB and 001 LH sign-extend from bit 7/15; 010 LW sign-extends from bit 31; 011 LD takes all 64 bits;
  - 100 LBU, 101 LHU and 110 LWU zero-extend; 111 is treated as LD.
- Store: funct3 000/001/010/011 selects size 1/2/4/8 bytes.
  - memWdata replicates the low size bytes of inStoreData across all lanes.
  - memStrb = size mask << addr[2:0].
- Exception flags are 0 whenever outValid is 0 or the access completed normally.

Decomposition:
- mem_stage_pkg:
  - state enum {IDLE, WAIT};
  - funct3 localparams (LB..LWU, SB..SD);
  - function size_mask(funct3) returning an 8-bit mask;
  - function is_aligned(funct3, addr[2:0]).
- Sub-module load_align: combinational memRdata, addr[2:0], funct3 to the 64-bit extended value.

Test Plan:
- Non-memory op: inResult=0x1234, inRegWrite=1, inDestReg=5 -> next cycle outValid=1, outResult=0x1234, outStall never 1.
- LB at addr 0x1003, memRdata=0x00000000_80000000 with memAck on the 3rd WAIT cycle -> memAddr=0x1000; outLoadData=0xFFFFFFFF_FFFFFF80 one cycle after ack; outStall high for 3 cycles.
- SH at 0x2006, inStoreData=0xABCD -> memWe=1, memStrb=0xC0, memWdata=0xABCDABCD_ABCDABCD; outRegWrite follows input (0).
- LW at 0x3002 -> no memReq, next cycle outMisaligned=1, outRegWrite=0.
- LD with memAck never asserted -> memReq high for exactly 255 cycles, then outBusError=1 and outStall=0; a repeat with ack on cycle 255 completes normally.
- reset asserted in the 2nd WAIT cycle -> memReq=0 and outValid=0 the next cycle; a later memAck has no effect.
